// File: rtl/vdc_regbank.sv
// VDC host-register bank: bus decode, frame-shadowed register file, R31 write queue, light-pen capture.
// Writes land one clock after the edge; db_out registered; queue is valid/ready with overflow flag on drop.
module vdc_regbank #(
  parameter int          NUM_REGS   = 38,
  parameter logic [63:0] DEFER_MASK = 64'h0000_0000_0300_1000,
  parameter bit          SHADOW_EN  = 1'b1,
  parameter int          QDEPTH     = 4,
  parameter int          LP_FILTER  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enableBus,
  input  logic                  cs,
  input  logic                  rs,
  input  logic                  we,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic [1:0]            version,
  input  logic                  busy,
  input  logic                  vVisible,
  input  logic                  frame_pulse,
  input  logic [7:0]            col,
  input  logic [7:0]            row,
  input  logic                  lp_n,
  input  logic [7:0]            rd_data,
  output logic [7:0]            q_data,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [NUM_REGS*8-1:0] regs
);

  localparam int          AW      = $clog2(QDEPTH);
  localparam int          CW      = $clog2(LP_FILTER + 1);
  localparam logic [63:0] SH_MASK = SHADOW_EN ? DEFER_MASK : 64'h0;

  logic [5:0]          reg_sel;
  logic [7:0]          live   [NUM_REGS];
  logic [7:0]          shadow [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [7:0]          live_ext [64];
  logic                ovf;
  logic                lp_status;

  // bus decode
  logic bus_wr, addr_wr, data_wr, sel_ok, wr_ok, rd_en, rd_lp;
  assign bus_wr  = cs & we & enableBus;
  assign addr_wr = bus_wr & ~rs;
  assign data_wr = bus_wr & rs;
  assign sel_ok  = {1'b0, reg_sel} < 7'(NUM_REGS);
  assign wr_ok   = data_wr & sel_ok & (reg_sel != 6'd16) & (reg_sel != 6'd17) &
                   ~((reg_sel == 6'd37) & (version != 2'd2));
  assign rd_en   = cs & ~we;
  assign rd_lp   = rd_en & rs & sel_ok & ((reg_sel == 6'd16) | (reg_sel == 6'd17));

  // R31 write queue
  logic [7:0]  mem [QDEPTH];
  logic [AW:0] wptr, rptr;
  logic        q_full, pop, push_req, push_ok, ovf_set;
  assign q_valid  = (wptr != rptr);
  assign q_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign q_data   = mem[rptr[AW-1:0]];
  assign pop      = q_valid & q_ready;
  assign push_req = wr_ok & (reg_sel == 6'd31);
  assign push_ok  = push_req & (~q_full | pop);
  assign ovf_set  = push_req & q_full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= db_in;
  end

  // light pen: 2-flop sync, then a level filter; capture on accepted release
  logic          lp_s1, lp_s2, lp_f;
  logic [CW-1:0] lp_cnt;
  logic          lp_acc, lp_cap;
  assign lp_acc = (lp_s2 != lp_f) && (lp_cnt == CW'(LP_FILTER - 1));
  assign lp_cap = lp_acc & lp_s2 & ~lp_status;

  genvar g;
  generate
    for (g = 0; g < 64; g++) begin : g_ext
      if (g < NUM_REGS) begin : g_on
        assign live_ext[g] = live[g];
      end else begin : g_off
        assign live_ext[g] = 8'hFF;
      end
    end
    for (g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[8*g +: 8] = live[g];
    end
  endgenerate

  // read path
  logic [7:0] rd_mask, rd_val, status;
  assign status = {~busy, lp_status, ~vVisible, ovf, 2'b00, version};

  always_comb begin
    rd_mask = 8'h00;
    case (reg_sel)
      6'd5, 6'd9, 6'd11, 6'd23, 6'd29: rd_mask = 8'hE0;
      6'd8:  rd_mask = 8'hFC;
      6'd10: rd_mask = 8'h80;
      6'd28: rd_mask = 8'h0F;
      6'd36: rd_mask = 8'hF0;
      6'd37: rd_mask = (version == 2'd2) ? 8'h3F : 8'hFF;
      default: rd_mask = 8'h00;
    endcase
    rd_val = 8'hFF;
    if (sel_ok) begin
      if (reg_sel == 6'd31)
        rd_val = rd_data;
      else if (reg_sel == 6'd22)
        rd_val = {4'h0, live_ext[22][7:4] & live_ext[22][3:0]};
      else
        rd_val = live_ext[reg_sel] | rd_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_sel   <= 6'd0;
      db_out    <= 8'h00;
      wptr      <= '0;
      rptr      <= '0;
      ovf       <= 1'b0;
      lp_status <= 1'b0;
      lp_s1     <= 1'b1;
      lp_s2     <= 1'b1;
      lp_f      <= 1'b1;
      lp_cnt    <= '0;
      pend      <= '0;
      for (int n = 0; n < NUM_REGS; n++) begin
        live[n]   <= 8'h00;
        shadow[n] <= 8'h00;
      end
    end else begin
      if (addr_wr) reg_sel <= db_in[5:0];

      if (rd_en) db_out <= rs ? rd_val : status;

      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (pop)     rptr <= rptr + (AW+1)'(1);

      if (rd_en & ~rs) ovf <= ovf_set;
      else if (ovf_set) ovf <= 1'b1;

      lp_s1 <= lp_n;
      lp_s2 <= lp_s1;
      if (lp_s2 == lp_f) begin
        lp_cnt <= '0;
      end else if (lp_acc) begin
        lp_f   <= lp_s2;
        lp_cnt <= '0;
      end else begin
        lp_cnt <= lp_cnt + CW'(1);
      end

      if (lp_cap)     lp_status <= 1'b1;
      else if (rd_lp) lp_status <= 1'b0;

      for (int n = 0; n < NUM_REGS; n++) begin
        if (frame_pulse && pend[n]) begin
          live[n] <= shadow[n];
          pend[n] <= 1'b0;
        end
        if (wr_ok && reg_sel == 6'(n)) begin
          if (n == 31) begin
            if (push_ok) live[n] <= db_in;
          end else if (SH_MASK[n]) begin
            // a write coinciding with the frame pulse goes straight to live
            if (frame_pulse) begin
              live[n] <= db_in;
              pend[n] <= 1'b0;
            end else begin
              shadow[n] <= db_in;
              pend[n]   <= 1'b1;
            end
          end else begin
            live[n] <= db_in;
          end
        end
        if (lp_cap && n == 16) live[n] <= row;
        if (lp_cap && n == 17) live[n] <= col;
      end
    end
  end

endmodule

// File: tb/tb_vdc_regbank.sv
// Scoreboard bench for vdc_regbank with default parameters.
module tb_vdc_regbank;
  logic         clk = 1'b0;
  logic         reset, enableBus, cs, rs, we;
  logic [7:0]   db_in, db_out;
  logic [1:0]   version;
  logic         busy, vVisible, frame_pulse;
  logic [7:0]   col, row, rd_data, q_data;
  logic         lp_n, q_valid, q_ready;
  logic [303:0] regs;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rdq[$];
  logic [7:0] qexp[$];

  vdc_regbank dut (
    .clk(clk), .reset(reset), .enableBus(enableBus), .cs(cs), .rs(rs), .we(we),
    .db_in(db_in), .db_out(db_out), .version(version), .busy(busy),
    .vVisible(vVisible), .frame_pulse(frame_pulse), .col(col), .row(row),
    .lp_n(lp_n), .rd_data(rd_data), .q_data(q_data), .q_valid(q_valid),
    .q_ready(q_ready), .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 0; we = 0; rs = 0; enableBus = 0;
  endtask

  task automatic wr(input logic r, input logic [7:0] d);
    cs = 1; we = 1; enableBus = 1; rs = r; db_in = d;
    cyc();
    idle();
  endtask

  task automatic rd(input string tag, input logic r, input logic [7:0] exp);
    rdq.push_back(exp);
    cs = 1; we = 0; enableBus = 0; rs = r;
    cyc();
    idle();
    check(tag, db_out, rdq.pop_front());
  endtask

  function automatic logic [7:0] rg(input int n);
    return regs[8*n +: 8];
  endfunction

  task automatic drain(input string tag);
    q_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_vld"}, q_valid, 1);
      check({tag, "_dat"}, q_data, qexp.pop_front());
      cyc();
    end
    q_ready = 0;
    check({tag, "_empty"}, q_valid, 0);
  endtask

  initial begin
    reset = 1; idle(); db_in = 0; version = 2'd2; busy = 0; vVisible = 1;
    frame_pulse = 0; col = 0; row = 0; lp_n = 1; rd_data = 0; q_ready = 0;
    repeat (3) cyc();
    check("rst_regs", {31'b0, |regs}, 0);
    check("rst_dbout", db_out, 0);
    check("rst_qvalid", q_valid, 0);
    reset = 0;
    cyc();

    // basic write / read
    wr(0, 8'd1); wr(1, 8'h50);
    check("r1_live", rg(1), 8'h50);
    rd("r1_read", 1, 8'h50);
    cyc();
    check("dbout_hold", db_out, 8'h50);
    wr(0, 8'd5); wr(1, 8'h00);
    rd("r5_mask", 1, 8'hE0);
    wr(0, 8'd22); wr(1, 8'hF6);
    rd("r22_and", 1, 8'h06);

    // shadowed registers
    wr(0, 8'd12); wr(1, 8'h12);
    wr(0, 8'd24); wr(1, 8'h77);
    check("r12_deferred", rg(12), 8'h00);
    check("r24_deferred", rg(24), 8'h00);
    frame_pulse = 1; cyc(); frame_pulse = 0;
    check("r12_applied", rg(12), 8'h12);
    check("r24_applied", rg(24), 8'h77);
    wr(0, 8'd12);
    frame_pulse = 1; wr(1, 8'h34); frame_pulse = 0;
    check("r12_same_cycle", rg(12), 8'h34);
    frame_pulse = 1; cyc(); frame_pulse = 0;
    check("r12_pend_clear", rg(12), 8'h34);

    // queue overflow
    wr(0, 8'd31);
    wr(1, 8'hAA); qexp.push_back(8'hAA);
    wr(1, 8'hBB); qexp.push_back(8'hBB);
    wr(1, 8'hCC); qexp.push_back(8'hCC);
    wr(1, 8'hDD); qexp.push_back(8'hDD);
    wr(1, 8'hEE);
    check("q_head", q_data, 8'hAA);
    rd("stat_ovf", 0, 8'h92);
    rd("stat_ovf_clr", 0, 8'h82);
    rd_data = 8'h5A;
    rd("r31_readback", 1, 8'h5A);
    drain("q1");

    // full queue with simultaneous push and pop
    for (int i = 1; i <= 4; i++) begin
      wr(1, 8'(i)); qexp.push_back(8'(i));
    end
    q_ready = 1;
    check("q_pp_head", q_data, qexp.pop_front());
    qexp.push_back(8'h11);
    wr(1, 8'h11);
    q_ready = 0;
    rd("stat_no_ovf", 0, 8'h82);
    drain("q2");

    // light pen
    col = 8'h2A; row = 8'h05;
    lp_n = 0; repeat (8) cyc();
    lp_n = 1; repeat (2) cyc();
    lp_n = 0; repeat (8) cyc();
    check("lp_glitch", rg(17), 8'h00);
    rd("stat_lp0", 0, 8'h82);
    lp_n = 1; repeat (8) cyc();
    check("lp_col", rg(17), 8'h2A);
    check("lp_row", rg(16), 8'h05);
    rd("stat_lp1", 0, 8'hC2);
    wr(0, 8'd16);
    rd("r16_read", 1, 8'h05);
    rd("stat_lp_clr", 0, 8'h82);
    lp_n = 0; repeat (8) cyc();
    col = 8'h3B; row = 8'h07;
    lp_n = 1; repeat (4) cyc();
    rd("r16_race", 1, 8'h05);
    check("lp_row2", rg(16), 8'h07);
    check("lp_col2", rg(17), 8'h3B);
    rd("stat_race", 0, 8'hC2);
    wr(1, 8'h99);
    check("r16_ro", rg(16), 8'h07);

    // R37 and out-of-range
    version = 2'd0;
    wr(0, 8'd37); wr(1, 8'hC0);
    rd("r37_v0", 1, 8'hFF);
    check("r37_v0_live", rg(37), 8'h00);
    version = 2'd2;
    wr(1, 8'hC0);
    rd("r37_v2", 1, 8'hFF);
    check("r37_v2_live", rg(37), 8'hC0);
    wr(1, 8'h80);
    rd("r37_80", 1, 8'hBF);
    wr(0, 8'd40);
    rd("r40_oob", 1, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vdc_regbank.md
Name: vdc_regbank

Overview:
Parametrised successor to the VDC host-register logic: CPU bus decode, register file, status and light-pen capture for 8563/8568-class VDCs. It generalises the register count and adds three things: frame-synchronous shadowing of selected registers, a queued R31 data-write path to the RAM interface with overflow detection, and a filtered light-pen input. It sits between the C128 bus and the VDC signal, RAM-interface and video blocks, and drives them a flat live-register bus.

Parameters:
NUM_REGS, 38, number of implemented registers (R0..NUM_REGS-1); the maximum is 64.
DEFER_MASK, 64'h0000_0000_0300_1000, bit n=1 makes Rn shadowed (defaults: R12, R24, R25).
SHADOW_EN, 1, 0 makes all registers immediate and ignores DEFER_MASK.
QDEPTH, 4, depth of the R31 write queue (power of 2, at least 2).
LP_FILTER, 3, number of consecutive clocks lp_n must hold a level to be accepted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enableBus  in  1  bus-write qualifier
cs  in  1  chip select
rs  in  1  register select (0=address/status, 1=data)
we  in  1  write enable
db_in  in  8  CPU data in
db_out  out  8  CPU data out (registered)
version  in  2  0=8563R7A, 1=8563R9, 2=8568
busy  in  1  RAM interface busy
vVisible  in  1  vertical visible area
frame_pulse  in  1  one-cycle pulse at vblank start
col  in  8  current column
row  in  8  current row
lp_n  in  1  light pen, asynchronous, active low
rd_data  in  8  last byte read by the RAM interface (R31 read-back)
q_data  out  8  head of the R31 write queue
q_valid  out  1  queue not empty
q_ready  in  1  RAM interface accepts the head this cycle
regs  out  NUM_REGS*8  live registers; Rn is at bits [8n+7:8n]

Behaviour:
- Reset: every register (live and shadow) = 0, regSel = 0, db_out = 0, queue empty, q_valid = 0, ovf = 0, lpStatus = 0, filter state = 1 (released). Reset has priority over every other event.
- Address write: on cs & we & enableBus & !rs, regSel <= db_in[5:0] on the next clock.
- Data write: on cs & we & enableBus & rs:
  - If regSel >= NUM_REGS, or regSel is 16 or 17, or regSel is 37 and version != 2: the write is ignored.
  - If regSel is 31: push db_in. If the queue is full, drop the byte and set ovf; R31 live is not updated.
  - If Rn is shadowed (SHADOW_EN & DEFER_MASK[n]): shadow[n] <= db_in and pend[n] <= 1.
  - Otherwise: live[n] <= db_in, visible on regs one clock after the write edge.
- Frame pulse: for every n with pend[n]=1, live[n] <= shadow[n] and pend[n] <= 0.
  - If a shadowed write and frame_pulse occur in the same cycle, the new db_in goes straight to live and pend for that register is cleared.
- Queue:
  - FIFO with QDEPTH entries; q_data = head, combinational from storage.
  - Pop when q_valid & q_ready.
  - A push and a pop in the same cycle on a full queue succeed, with no overflow.
  - A pop on an empty queue is ignored.
  - Pointers are log2(QDEPTH)+1 bits and wrap.
- Read (cs & !we, no enableBus qualification): db_out is updated on the next clock and holds its value otherwise.
  - Status (rs=0): {~busy, lpStatus, ~vVisible, ovf, 2'b00, version}. The read clears ovf unless an overflow occurs in the same cycle.
  - Data (rs=1): the live register OR'd with its read mask:
    - R5, R9, R11, R23, R29: mask E0.
    - R8: FC.
    - R10: 80.
    - R28: 0F.
    - R36: F0.
    - R37: 3F, or FF when version != 2.
  - R31 returns rd_data.
  - R16/R17 return the light-pen latches and clear lpStatus.
  - R22 returns {R22[7:4] & R22[3:0]} zero-extended.
  - regSel >= NUM_REGS returns FF.
- Light pen:
  - lp_n passes through a 2-flop synchroniser, then a filter that accepts a new level only after LP_FILTER equal consecutive samples.
  - On an accepted 0->1 transition with lpStatus=0: R17 <= col, R16 <= row, lpStatus <= 1.
  - If a capture and a clearing R16/R17 read occur in the same cycle, the capture wins: lpStatus stays 1 and the latches hold the new values. db_out carries the old value.
- regs exposes live values only; shadow contents are never visible on regs.

Test Plan:
- Reset, then write addr 1 and data 50 -> regs[15:8]=50 one clock later; a read of R1 gives db_out=50; a read of R5 after writing 00 gives E0.
- Write R12=12 with SHADOW_EN=1 -> regs[103:96] stays 00 until frame_pulse, then becomes 12; with the write and frame_pulse in the same cycle -> 12 immediately and pend cleared.
- QDEPTH=4, q_ready=0, five R31 writes AA,BB,CC,DD,EE -> q_valid=1, q_data=AA, status bit4=1, EE lost. A status read clears bit4. q_ready=1 for 4 cycles pops AA,BB,CC,DD, then q_valid=0.
- Full queue plus simultaneous push 11 and pop -> no overflow; 11 is the last entry.
- lp_n glitch low->high for 2 clocks (LP_FILTER=3) -> no capture. A clean rise with col=2A, row=05 -> R17=2A, R16=05, status bit6=1. A read of R16 -> 05 and bit6 clears. A capture in the same cycle as the read -> bit6 stays 1.
- version=0: writing R37=C0 and reading it back -> FF. version=2 -> C0|3F=FF and R37 live=C0. Write 80 -> read BF. regSel=40 with NUM_REGS=38 -> FF.
